// File: rtl/dtfag_req_seq.sv
`default_nettype none
// ============================================================================
//  Module   : dtfag_req_seq
//  Purpose  : Walks the (t,j,i) index space into DTFAG_top, captures the ROM
//             banks after the AGU+ROM latency and queues them for the datapath.
//  Revision : 1.0  initial release
// ============================================================================
module dtfag_req_seq #(
  parameter int RADIX_W  = 4,
  parameter int D_W      = 64,
  parameter int ROM_LAT  = 2,
  parameter int FIFO_DEP = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [RADIX_W-1:0]  cfg_t_last,
  input  logic [RADIX_W-1:0]  cfg_j_last,
  input  logic [RADIX_W-1:0]  cfg_i_last,
  output logic [RADIX_W-1:0]  DTFAG_t,
  output logic [RADIX_W-1:0]  DTFAG_j,
  output logic [RADIX_W-1:0]  DTFAG_i,
  output logic                ROM_CEN,
  input  logic [16*D_W-1:0]   rom0_data,
  input  logic [16*D_W-1:0]   rom1_data,
  input  logic [16*D_W-1:0]   rom2_data,
  output logic                tw_valid,
  input  logic                tw_ready,
  output logic [48*D_W-1:0]   tw_data,
  output logic                tw_last,
  output logic                busy,
  output logic                done
);

  localparam int c_cnt_w = $clog2(FIFO_DEP + 1);
  localparam int c_inf_w = $clog2(ROM_LAT + 1);
  localparam int c_ptr_w = (FIFO_DEP > 1) ? $clog2(FIFO_DEP) : 1;
  localparam int c_sum_w = ((c_cnt_w > c_inf_w) ? c_cnt_w : c_inf_w) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [RADIX_W-1:0]   r_t;
  logic [RADIX_W-1:0]   r_j;
  logic [RADIX_W-1:0]   r_i;
  logic [RADIX_W-1:0]   r_t_last;
  logic [RADIX_W-1:0]   r_j_last;
  logic [RADIX_W-1:0]   r_i_last;

  logic                 w_issue;
  logic                 w_at_end;

  logic [ROM_LAT-1:0]   r_pipe_vld;
  logic [ROM_LAT-1:0]   r_pipe_last;
  logic [c_inf_w-1:0]   w_inflight;
  logic [c_sum_w-1:0]   w_credit_used;

  logic [48*D_W-1:0]    r_mem [FIFO_DEP];
  logic [FIFO_DEP-1:0]  r_mem_last;
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_cnt_w-1:0]   r_fifo_cnt;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_fifo_empty;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign w_at_end = (r_t == r_t_last) && (r_j == r_j_last) && (r_i == r_i_last);

  // Credit covers both queued entries and reads still travelling through the ROM,
  // so every issued read is guaranteed a FIFO slot when its data returns.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_issue = (w_credit_used < c_sum_w'(FIFO_DEP));
        if (w_issue && w_at_end) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (done || (w_fifo_empty && (r_pipe_vld == '0))) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign ROM_CEN = ~w_issue;
  assign busy    = (r_state != S_IDLE);

  // ---------------------------------------------------------------- index counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_t      <= '0;
      r_j      <= '0;
      r_i      <= '0;
      r_t_last <= '0;
      r_j_last <= '0;
      r_i_last <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_t      <= '0;
      r_j      <= '0;
      r_i      <= '0;
      r_t_last <= cfg_t_last;
      r_j_last <= cfg_j_last;
      r_i_last <= cfg_i_last;
    end else if (w_issue) begin
      if (r_i == r_i_last) begin
        r_i <= '0;
        if (r_j == r_j_last) begin
          r_j <= '0;
          r_t <= (r_t == r_t_last) ? '0 : r_t + 1'b1;
        end else begin
          r_j <= r_j + 1'b1;
        end
      end else begin
        r_i <= r_i + 1'b1;
      end
    end
  end

  assign DTFAG_t = r_t;
  assign DTFAG_j = r_j;
  assign DTFAG_i = r_i;

  // ---------------------------------------------------------------- latency pipe
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pipe_vld  <= '0;
      r_pipe_last <= '0;
    end else begin
      r_pipe_vld[0]  <= w_issue;
      r_pipe_last[0] <= w_issue && w_at_end;
      for (int k = 1; k < ROM_LAT; k++) begin
        r_pipe_vld[k]  <= r_pipe_vld[k-1];
        r_pipe_last[k] <= r_pipe_last[k-1];
      end
    end
  end

  always_comb begin
    w_inflight = '0;
    for (int k = 0; k < ROM_LAT; k++) begin
      w_inflight = w_inflight + c_inf_w'(r_pipe_vld[k]);
    end
  end

  assign w_credit_used = c_sum_w'(r_fifo_cnt) + c_sum_w'(w_inflight);

  // ---------------------------------------------------------------- output FIFO
  assign w_push       = r_pipe_vld[ROM_LAT-1];
  assign w_fifo_empty = (r_fifo_cnt == '0);
  assign w_pop        = tw_valid && tw_ready;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr]      <= {rom2_data, rom1_data, rom0_data};
      r_mem_last[r_wr_ptr] <= r_pipe_last[ROM_LAT-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == c_ptr_w'(FIFO_DEP - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_ptr_w'(FIFO_DEP - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  assign tw_valid = ~w_fifo_empty;
  assign tw_data  = r_mem[r_rd_ptr];
  assign tw_last  = tw_valid && r_mem_last[r_rd_ptr];
  assign done     = w_pop && r_mem_last[r_rd_ptr];

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && !w_pop && (r_fifo_cnt == c_cnt_w'(FIFO_DEP))));
`endif

endmodule
`default_nettype wire

// File: tb/tb_dtfag_req_seq.sv
`default_nettype none
// Testbench for dtfag_req_seq: DTFAG_top ROM model, table of sweeps plus
// hand-written reset-mid-sweep sequence.
module tb_dtfag_req_seq;

  localparam int RADIX_W  = 4;
  localparam int D_W      = 64;
  localparam int ROM_LAT  = 2;
  localparam int FIFO_DEP = 4;
  localparam int EW       = 48 * D_W;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [RADIX_W-1:0] cfg_t_last = '0;
  logic [RADIX_W-1:0] cfg_j_last = '0;
  logic [RADIX_W-1:0] cfg_i_last = '0;
  logic [RADIX_W-1:0] DTFAG_t;
  logic [RADIX_W-1:0] DTFAG_j;
  logic [RADIX_W-1:0] DTFAG_i;
  logic               ROM_CEN;
  logic [16*D_W-1:0]  rom0_data = '0;
  logic [16*D_W-1:0]  rom1_data = '0;
  logic [16*D_W-1:0]  rom2_data = '0;
  logic               tw_valid;
  logic               tw_ready = 1'b0;
  logic [EW-1:0]      tw_data;
  logic               tw_last;
  logic               busy;
  logic               done;

  int n_chk  = 0;
  int n_pass = 0;

  dtfag_req_seq #(
    .RADIX_W  (RADIX_W),
    .D_W      (D_W),
    .ROM_LAT  (ROM_LAT),
    .FIFO_DEP (FIFO_DEP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_t_last (cfg_t_last),
    .cfg_j_last (cfg_j_last),
    .cfg_i_last (cfg_i_last),
    .DTFAG_t    (DTFAG_t),
    .DTFAG_j    (DTFAG_j),
    .DTFAG_i    (DTFAG_i),
    .ROM_CEN    (ROM_CEN),
    .rom0_data  (rom0_data),
    .rom1_data  (rom1_data),
    .rom2_data  (rom2_data),
    .tw_valid   (tw_valid),
    .tw_ready   (tw_ready),
    .tw_data    (tw_data),
    .tw_last    (tw_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Every twiddle word encodes bank, word index and the triple that produced it.
  function automatic logic [EW-1:0] f_entry(input int t, input int j, input int i);
    logic [EW-1:0] e;
    e = '0;
    for (int b = 0; b < 3; b++)
      for (int k = 0; k < 16; k++)
        e[(b*16+k)*D_W +: D_W] = {8'(b), 8'(k), 8'(t), 8'(j), 8'(i), 8'hA5, 8'(t*16+j), 8'(~i)};
    return e;
  endfunction

  // DTFAG_top model: AGU register, then ROM read register; junk when no read.
  logic               m_v = 1'b0;
  logic [RADIX_W-1:0] m_t = '0, m_j = '0, m_i = '0;
  always @(posedge clk) begin
    m_v <= !ROM_CEN;
    m_t <= DTFAG_t;
    m_j <= DTFAG_j;
    m_i <= DTFAG_i;
    if (m_v) {rom2_data, rom1_data, rom0_data} <= f_entry(int'(m_t), int'(m_j), int'(m_i));
    else     {rom2_data, rom1_data, rom0_data} <= f_entry(int'(m_t), int'(m_j), int'(m_i)) ^ {96{32'hDEAD_BEEF}};
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_data(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got low128 %h expected low128 %h", name, act[127:0], exp[127:0]);
  endtask

  typedef struct {
    int t;
    int j;
    int i;
    int mode;    // 0: ready=1, 1: random 30% ready, 2: ready low for 10 cycles
    int inject;  // sample index at which a stray start is pulsed (-1 none)
    int n;       // expected sweep length
  } vec_t;

  task automatic step(inout int a, inout int b, inout int c, input vec_t v);
    if (c < v.i) c++;
    else begin
      c = 0;
      if (b < v.j) b++;
      else begin
        b = 0;
        a = (a < v.t) ? a + 1 : 0;
      end
    end
  endtask

  task automatic run_sweep(input vec_t v, input string tag);
    int et = 0, ej = 0, ei = 0, pt = 0, pj = 0, pi = 0;
    int issued = 0, popped = 0, cyc = 0, budget;
    int q_issue[$];
    bit fin = 0;
    bit exp_v;
    budget = v.n * 12 + 200;
    @(negedge clk);
    cfg_t_last = RADIX_W'(v.t);
    cfg_j_last = RADIX_W'(v.j);
    cfg_i_last = RADIX_W'(v.i);
    start      = 1'b1;
    tw_ready   = 1'b1;
    while (!fin && cyc < budget) begin
      @(negedge clk);
      start = (cyc == v.inject);
      {cfg_t_last, cfg_j_last, cfg_i_last} = 12'($urandom);
      case (v.mode)
        1:       tw_ready = ($urandom_range(99) < 30);
        2:       tw_ready = !(cyc >= 6 && cyc < 16);
        default: tw_ready = 1'b1;
      endcase
      #1;
      chk({tag, " busy"}, 64'(busy), 64'd1);
      chk({tag, " rom_cen"}, 64'(ROM_CEN),
          64'(!(issued < v.n && (issued - popped) < FIFO_DEP)));
      chk({tag, " idx"}, 64'({DTFAG_t, DTFAG_j, DTFAG_i}),
          64'({RADIX_W'(et), RADIX_W'(ej), RADIX_W'(ei)}));
      if (!ROM_CEN) begin
        q_issue.push_back(cyc);
        issued++;
        step(et, ej, ei, v);
      end
      // An entry issued at sample c becomes visible at sample c+ROM_LAT+1.
      exp_v = (popped < q_issue.size()) && (q_issue[popped] + ROM_LAT + 1 <= cyc);
      chk({tag, " tw_valid"}, 64'(tw_valid), 64'(exp_v));
      if (tw_valid) begin
        chk_data({tag, " tw_data"}, tw_data, f_entry(pt, pj, pi));
        chk({tag, " tw_last"}, 64'(tw_last), 64'(popped == v.n - 1));
        chk({tag, " done"}, 64'(done), 64'(tw_ready && popped == v.n - 1));
        if (tw_ready) begin
          if (popped == v.n - 1) fin = 1;
          popped++;
          step(pt, pj, pi, v);
        end
      end else begin
        chk({tag, " done_idle"}, 64'(done), 64'd0);
      end
      cyc++;
    end
    if (!fin) begin
      n_chk++;
      $display("FAIL %s timeout: popped %0d required %0d", tag, popped, v.n);
    end
    start = 1'b0;
    @(negedge clk);
    #1;
    chk({tag, " busy_after"}, 64'(busy), 64'd0);
    chk({tag, " valid_after"}, 64'(tw_valid), 64'd0);
    chk({tag, " cen_after"}, 64'(ROM_CEN), 64'd1);
    chk({tag, " pops"}, 64'(popped), 64'(v.n));
    chk({tag, " issues"}, 64'(issued), 64'(v.n));
  endtask

  vec_t vecs[8];
  vec_t vr;
  int   iss;

  initial begin
    vecs[0] = '{t: 0,  j: 0,  i: 0,  mode: 0, inject: -1, n: 1};
    vecs[1] = '{t: 1,  j: 1,  i: 2,  mode: 0, inject: -1, n: 12};
    vecs[2] = '{t: 1,  j: 1,  i: 2,  mode: 0, inject: 4,  n: 12};
    vecs[3] = '{t: 2,  j: 3,  i: 4,  mode: 1, inject: -1, n: 60};
    vecs[4] = '{t: 0,  j: 0,  i: 3,  mode: 2, inject: -1, n: 4};
    vecs[5] = '{t: 2,  j: 0,  i: 0,  mode: 1, inject: -1, n: 3};
    vecs[6] = '{t: 0,  j: 3,  i: 1,  mode: 0, inject: 9,  n: 8};
    vecs[7] = '{t: 15, j: 15, i: 15, mode: 2, inject: -1, n: 4096};

    repeat (3) @(negedge clk);
    chk("reset rom_cen", 64'(ROM_CEN), 64'd1);
    chk("reset idx", 64'({DTFAG_t, DTFAG_j, DTFAG_i}), 64'd0);
    chk("reset tw_valid", 64'(tw_valid), 64'd0);
    chk("reset tw_last", 64'(tw_last), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    rst = 1'b0;

    for (int v = 0; v < 8; v++) run_sweep(vecs[v], $sformatf("vec%0d", v));

    // Reset in the middle of a long sweep after five issues.
    @(negedge clk);
    {cfg_t_last, cfg_j_last, cfg_i_last} = 12'hFFF;
    start    = 1'b1;
    tw_ready = 1'b1;
    iss      = 0;
    for (int c = 0; c < 50 && iss < 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (!ROM_CEN) iss++;
    end
    chk("rstmid issues", 64'(iss), 64'd5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstmid rom_cen", 64'(ROM_CEN), 64'd1);
    chk("rstmid tw_valid", 64'(tw_valid), 64'd0);
    chk("rstmid busy", 64'(busy), 64'd0);
    chk("rstmid idx", 64'({DTFAG_t, DTFAG_j, DTFAG_i}), 64'd0);
    vr = '{t: 0, j: 1, i: 1, mode: 0, inject: -1, n: 4};
    run_sweep(vr, "restart");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
